// File: rtl/shot_controller_pkg.sv
// Shared game definitions: shot FSM states and default timing/power constants,
// so the power-bar renderer and the shot controller agree on MAX_POWER.
package shot_controller_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHARGE,
      FIRE,
      FLIGHT,
      SWITCH
   } shot_state_t;

   localparam int unsigned POWER_W           = 8;
   localparam int unsigned DEF_STEP_INTERVAL = 1_234_177;
   localparam int unsigned DEF_MAX_POWER     = 128;
   localparam int unsigned DEF_COOLDOWN      = 65_000_000;

endpackage

// File: rtl/shot_controller_if.sv
// Player keys, projectile/halt inputs and shot outputs between the game and the shot controller.
interface shot_controller_if;
   import shot_controller_pkg::*;

   logic               space_p1;
   logic               space_p2;
   logic               projectile_done;
   logic               halt;
   logic               active_player;
   logic               bar_on;
   logic [POWER_W-1:0] charge_level;
   logic               fire;
   logic [POWER_W-1:0] shot_power;
   logic               busy;

   modport master (
      output space_p1, space_p2, projectile_done, halt,
      input  active_player, bar_on, charge_level, fire, shot_power, busy
   );

   modport slave (
      input  space_p1, space_p2, projectile_done, halt,
      output active_player, bar_on, charge_level, fire, shot_power, busy
   );

endinterface

// File: rtl/shot_controller_key_edge_detect.sv
// Registered key copy with rising-edge output; load replaces the copy on a turn change.
module key_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic key,
   input  logic load,
   input  logic load_value,
   output logic rise
);

   logic key_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= 1'b0;
      end else if (load) begin
         key_q <= load_value;
      end else begin
         key_q <= key;
      end
   end

   assign rise = key & ~key_q;

endmodule

// File: rtl/shot_controller.sv
// Turn-based shot controller: charge while the active player's key is held,
// fire on release, wait for the projectile, then hand the turn over after a cooldown.
module shot_controller
   import shot_controller_pkg::*;
#(
   parameter int unsigned STEP_INTERVAL = DEF_STEP_INTERVAL,
   parameter int unsigned MAX_POWER     = DEF_MAX_POWER,
   parameter int unsigned COOLDOWN      = DEF_COOLDOWN
) (
   input logic            clk,
   input logic            rst,
   shot_controller_if.slave bus
);

   localparam int unsigned        STEP_W    = $clog2(STEP_INTERVAL + 2);
   localparam int unsigned        COOL_W    = $clog2(COOLDOWN + 2);
   localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_INTERVAL);
   localparam logic [COOL_W-1:0]  COOL_LAST = COOL_W'(COOLDOWN - 1);
   localparam logic [POWER_W-1:0] POWER_MAX = POWER_W'(MAX_POWER);

   shot_state_t        state, state_nxt;
   logic [STEP_W-1:0]  step, step_nxt;
   logic [COOL_W-1:0]  cool, cool_nxt;
   logic [POWER_W-1:0] charge, charge_nxt;
   logic [POWER_W-1:0] power, power_nxt;
   logic               player, player_nxt;
   logic               fire_q, bar_q, busy_q;
   logic               key, other_key, rise, load;

   assign key       = player ? bus.space_p2 : bus.space_p1;
   assign other_key = player ? bus.space_p1 : bus.space_p2;

   // On the turn toggle the edge register takes the incoming player's key,
   // so a key already held by that player does not count as a press.
   key_edge_detect u_key (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .load       (load),
      .load_value (other_key),
      .rise       (rise)
   );

   always_comb begin
      state_nxt  = state;
      step_nxt   = step;
      cool_nxt   = cool;
      charge_nxt = charge;
      power_nxt  = power;
      player_nxt = player;
      load       = 1'b0;
      if (bus.halt) begin
         state_nxt  = IDLE;
         step_nxt   = '0;
         cool_nxt   = '0;
         charge_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_nxt  = CHARGE;
                  step_nxt   = '0;
                  charge_nxt = '0;
               end
            end
            CHARGE: begin
               if (!key) begin
                  step_nxt   = '0;
                  charge_nxt = '0;
                  if (charge != '0) begin
                     state_nxt = FIRE;
                     power_nxt = charge;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else if (charge < POWER_MAX) begin
                  if (step == STEP_LAST) begin
                     step_nxt   = '0;
                     charge_nxt = charge + 1'b1;
                  end else begin
                     step_nxt = step + 1'b1;
                  end
               end
            end
            FIRE: state_nxt = FLIGHT;
            FLIGHT: begin
               if (bus.projectile_done) begin
                  state_nxt  = SWITCH;
                  player_nxt = ~player;
                  cool_nxt   = '0;
                  load       = 1'b1;
               end
            end
            SWITCH: begin
               if (cool == COOL_LAST) begin
                  state_nxt = IDLE;
                  cool_nxt  = '0;
               end else begin
                  cool_nxt = cool + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         step   <= '0;
         cool   <= '0;
         charge <= '0;
         power  <= '0;
         player <= 1'b0;
         fire_q <= 1'b0;
         bar_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         step   <= step_nxt;
         cool   <= cool_nxt;
         charge <= charge_nxt;
         power  <= power_nxt;
         player <= player_nxt;
         fire_q <= (state_nxt == FIRE);
         bar_q  <= (state_nxt == CHARGE);
         busy_q <= (state_nxt == FIRE) || (state_nxt == FLIGHT) || (state_nxt == SWITCH);
      end
   end

   assign bus.active_player = player;
   assign bus.bar_on        = bar_q;
   assign bus.charge_level  = charge;
   assign bus.fire          = fire_q;
   assign bus.shot_power    = power;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller with a per-cycle behavioural model and literal spot checks.
module tb_shot_controller;

   localparam int STEP = 3;
   localparam int MAXP = 128;
   localparam int COOL = 10;

   localparam int PH_IDLE   = 0;
   localparam int PH_CHARGE = 1;
   localparam int PH_FIRE   = 2;
   localparam int PH_FLIGHT = 3;
   localparam int PH_SWITCH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   shot_controller_if bus ();

   shot_controller #(
      .STEP_INTERVAL (STEP),
      .MAX_POWER     (MAXP),
      .COOLDOWN      (COOL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int fire_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: charge is derived from how long the key has been held in the charging phase.
   int m_phase  = PH_IDLE;
   int m_held   = 0;
   int m_age    = 0;
   int m_player = 0;
   int m_power  = 0;
   int m_keyq   = 0;
   bit m_valid  = 1'b0;

   function automatic int charge_of(input int held);
      int c;
      c = held / (STEP + 1);
      return (c > MAXP) ? MAXP : c;
   endfunction

   always @(posedge clk) begin
      int k;
      bit press;
      k     = m_player ? int'(bus.space_p2) : int'(bus.space_p1);
      press = (k == 1) && (m_keyq == 0);
      if (rst) begin
         m_phase  = PH_IDLE;
         m_held   = 0;
         m_age    = 0;
         m_player = 0;
         m_power  = 0;
         m_keyq   = 0;
         m_valid  = 1'b1;
      end else begin
         if (bus.halt) begin
            m_phase = PH_IDLE;
            m_held  = 0;
         end else begin
            case (m_phase)
               PH_IDLE: if (press) begin
                  m_phase = PH_CHARGE;
                  m_held  = 0;
               end
               PH_CHARGE: begin
                  if (k == 0) begin
                     if (charge_of(m_held) > 0) begin
                        m_power = charge_of(m_held);
                        m_phase = PH_FIRE;
                     end else begin
                        m_phase = PH_IDLE;
                     end
                     m_held = 0;
                  end else begin
                     m_held++;
                  end
               end
               PH_FIRE: m_phase = PH_FLIGHT;
               PH_FLIGHT: if (bus.projectile_done) begin
                  m_phase  = PH_SWITCH;
                  m_player = 1 - m_player;
                  m_age    = 0;
               end
               default: begin
                  m_age++;
                  if (m_age == COOL) m_phase = PH_IDLE;
               end
            endcase
         end
         m_keyq = m_player ? int'(bus.space_p2) : int'(bus.space_p1);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("player", bus.active_player, m_player);
         check("bar_on", bus.bar_on, (m_phase == PH_CHARGE));
         check("charge_level", bus.charge_level, (m_phase == PH_CHARGE) ? charge_of(m_held) : 0);
         check("fire", bus.fire, (m_phase == PH_FIRE));
         check("shot_power", bus.shot_power, m_power);
         check("busy", bus.busy, (m_phase >= PH_FIRE));
      end
      if (bus.fire === 1'b1) fire_cnt++;
   end

   initial begin
      int n;
      bus.space_p1        = 1'b0;
      bus.space_p2        = 1'b0;
      bus.projectile_done = 1'b0;
      bus.halt            = 1'b0;
      rst = 1'b1;
      tick(3);
      check("reset_fire", bus.fire, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_bar", bus.bar_on, 0);
      check("reset_charge", bus.charge_level, 0);
      check("reset_power", bus.shot_power, 0);
      check("reset_player", bus.active_player, 0);
      rst = 1'b0;

      // other player's key and stray projectile_done during P1's idle turn
      for (int i = 0; i < 8; i++) begin
         bus.space_p2        = (i % 2 == 0);
         bus.projectile_done = (i == 3 || i == 6);
         tick(1);
         check("spurious_bar", bus.bar_on, 0);
         check("spurious_busy", bus.busy, 0);
      end
      bus.space_p2        = 1'b0;
      bus.projectile_done = 1'b0;

      // tap: two-cycle press never charges
      bus.space_p1 = 1'b1;
      tick(2);
      check("tap_charging", bus.bar_on, 1);
      bus.space_p1 = 1'b0;
      tick(1);
      check("tap_idle", bus.bar_on, 0);
      check("tap_busy", bus.busy, 0);
      tick(2);
      check("tap_no_fire", fire_cnt, 0);
      check("tap_power", bus.shot_power, 0);

      // halt in the same cycle as release
      bus.space_p1 = 1'b1;
      tick(21);
      check("halt_pre_charge", bus.charge_level, 5);
      bus.space_p1 = 1'b0;
      bus.halt     = 1'b1;
      tick(1);
      check("halt_charge", bus.charge_level, 0);
      check("halt_bar", bus.bar_on, 0);
      check("halt_fire", bus.fire, 0);
      bus.space_p1 = 1'b1;
      tick(3);
      check("halt_blocks_press", bus.bar_on, 0);
      bus.space_p1 = 1'b0;
      tick(1);
      bus.halt = 1'b0;
      tick(1);
      check("halt_no_fire", fire_cnt, 0);

      // basic shot with noise on the other key and projectile_done while charging
      bus.space_p1 = 1'b1;
      for (int i = 0; i < 41; i++) begin
         bus.space_p2        = (i % 2 == 1);
         bus.projectile_done = (i == 20);
         tick(1);
      end
      bus.space_p2        = 1'b0;
      bus.projectile_done = 1'b0;
      check("basic_charge", bus.charge_level, 10);
      bus.space_p1 = 1'b0;
      tick(1);
      check("basic_fire", bus.fire, 1);
      check("basic_power", bus.shot_power, 10);
      check("basic_busy", bus.busy, 1);
      tick(1);
      check("basic_fire_once", bus.fire, 0);

      // handover while P2 already holds its key
      bus.space_p2 = 1'b1;
      tick(3);
      bus.projectile_done = 1'b1;
      tick(1);
      bus.projectile_done = 1'b0;
      check("handover_player", bus.active_player, 1);
      n = 0;
      while (bus.busy === 1'b1 && n < 50) begin
         n++;
         tick(1);
      end
      check("handover_switch_len", n, 10);
      tick(5);
      check("handover_held_no_charge", bus.bar_on, 0);
      bus.space_p2 = 1'b0;
      tick(2);
      bus.space_p2 = 1'b1;
      tick(9);
      check("p2_charge", bus.charge_level, 2);
      bus.space_p2 = 1'b0;
      tick(1);
      check("p2_fire", bus.fire, 1);
      check("p2_power", bus.shot_power, 2);
      tick(1);
      bus.projectile_done = 1'b1;
      tick(1);
      bus.projectile_done = 1'b0;
      check("back_to_p1", bus.active_player, 0);
      tick(10);
      check("back_idle", bus.busy, 0);

      // saturation
      bus.space_p1 = 1'b1;
      tick(1000);
      check("sat_charge", bus.charge_level, 128);
      bus.space_p1 = 1'b0;
      tick(1);
      check("sat_fire", bus.fire, 1);
      check("sat_power", bus.shot_power, 128);
      tick(2);

      // reset during flight, then during charge
      rst = 1'b1;
      tick(1);
      check("rst_flight_fire", bus.fire, 0);
      check("rst_flight_busy", bus.busy, 0);
      check("rst_flight_power", bus.shot_power, 0);
      rst = 1'b0;
      tick(2);
      bus.space_p1 = 1'b1;
      tick(12);
      rst = 1'b1;
      bus.space_p1 = 1'b0;
      tick(1);
      check("rst_charge_fire", bus.fire, 0);
      check("rst_charge_level", bus.charge_level, 0);
      rst = 1'b0;
      tick(3);
      check("total_fires", fire_cnt, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
